// File: rtl/pa_encoder.sv
// pa_encoder: splits 4-bit register addresses into set_pa / lower fields
// behind an in-order FIFO. Optional macro: ROE_PA_ALWAYS_SET_EN.
module pa_encoder #(
    parameter int DEPTH = 4,
    parameter int PW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_addr,
    input  logic [PW-1:0] in_payload,
    input  logic          pa_invalidate,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2:0]    out_set_pa,
    output logic [1:0]    out_lower_reg_addr,
    output logic [PW-1:0] out_payload,
    output logic [7:0]    pa_set_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 5 + PW;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    shadow_pa_q, shadow_pa_d;
    logic          shadow_ok_q, shadow_ok_d;
    logic [7:0]    set_cnt_q, set_cnt_d;

    logic          push;
    logic          pop;
    logic          need;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Decide whether this beat must rewrite the decoder's play area
    always_comb begin
`ifdef ROE_PA_ALWAYS_SET_EN
        need = 1'b1;
`else
        need = !shadow_ok_q || pa_invalidate
             || (in_addr[3:2] != shadow_pa_q);
`endif
    end

    // Entry layout {need, pa, lower, payload} == {set_pa, lower, payload}
    assign entry = {need, in_addr, in_payload};

    assign head               = mem_q[rd_ptr_q];
    assign out_set_pa         = head[EW-1 -: 3];
    assign out_lower_reg_addr = head[PW+1:PW];
    assign out_payload        = head[PW-1:0];
    assign pa_set_count       = set_cnt_q;

    // Next-state: FIFO push/pop, shadow tracking, saturating counter
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        shadow_pa_d = shadow_pa_q;
        shadow_ok_d = shadow_ok_q;
        set_cnt_d   = set_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            shadow_pa_d     = in_addr[3:2];
            shadow_ok_d     = 1'b1;
            if (need && set_cnt_q != 8'hFF) begin
                set_cnt_d = set_cnt_q + 8'd1;
            end
        end else if (pa_invalidate) begin
            shadow_ok_d = 1'b0;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset also clears storage so head fields read 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            shadow_pa_q <= 2'b00;
            shadow_ok_q <= 1'b1;
            set_cnt_q   <= 8'd0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            shadow_pa_q <= shadow_pa_d;
            shadow_ok_q <= shadow_ok_d;
            set_cnt_q   <= set_cnt_d;
        end
    end

endmodule
